// File: rtl/edge_detect_filter.sv
// Multi-channel input synchroniser, glitch filter and edge-pulse generator.
// Optional sticky event flags are built when EDGE_DETECT_STICKY_EN is defined.
module edge_detect_filter #(
  parameter int unsigned CH          = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter logic        RST_LEVEL   = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [CH-1:0]   sig_in,
  input  logic [2*CH-1:0] edge_mode,
  output logic [CH-1:0]   level_out,
  output logic [CH-1:0]   rise_pulse,
  output logic [CH-1:0]   fall_pulse,
  output logic [CH-1:0]   evt_pulse,
  output logic [CH-1:0]   sticky_flag,
  input  logic [CH-1:0]   sticky_clr
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CntW-1:0]        r_cnt;
    logic                   r_lvl;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s_sync;
    logic [CntW-1:0]        w_cnt_d;
    logic                   w_lvl_d;
    logic                   w_rise_d;
    logic                   w_fall_d;

    assign w_s_sync = r_sync[SYNC_STAGES-1];

    // Level only flips after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
      w_cnt_d  = '0;
      w_lvl_d  = r_lvl;
      w_rise_d = 1'b0;
      w_fall_d = 1'b0;
      if (w_s_sync != r_lvl) begin
        if (r_cnt == CntMax) begin
          w_lvl_d  = ~r_lvl;
          w_rise_d = ~r_lvl;
          w_fall_d = r_lvl;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_sync <= {SYNC_STAGES{RST_LEVEL}};
        r_cnt  <= '0;
        r_lvl  <= RST_LEVEL;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[i]};
        r_cnt  <= w_cnt_d;
        r_lvl  <= w_lvl_d;
        r_rise <= w_rise_d;
        r_fall <= w_fall_d;
      end
    end

    assign level_out[i]  = r_lvl;
    assign rise_pulse[i] = r_rise;
    assign fall_pulse[i] = r_fall;
    assign evt_pulse[i]  = (r_rise & edge_mode[2*i]) | (r_fall & edge_mode[2*i+1]);
  end

`ifdef EDGE_DETECT_STICKY_EN
  logic [CH-1:0] r_sticky;

  // A set in the same cycle as a clear wins so no event is lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~sticky_clr) | evt_pulse;
    end
  end

  assign sticky_flag = r_sticky;
`else
  logic [CH-1:0] w_unused_clr;
  assign w_unused_clr = sticky_clr;
  assign sticky_flag  = '0;
`endif

endmodule
